// File: rtl/axis_pkt_rx_pkg.sv
// Shared types and helpers for the AXI-Stream store-and-forward packet receiver.
package axis_pkt_rx_pkg;

  typedef enum logic {RECV = 1'b0, DROP = 1'b1} wr_state_e;
  typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_rx_len_fifo.sv
// Synchronous FIFO of committed packet lengths; head is visible combinationally.
module axis_pkt_rx_len_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI-Stream store-and-forward packet receiver with whole-packet drop on overflow.
// Optional macro AXIS_RX_STALL_EN adds stall_cfg backpressure injection after each accepted beat.
module axis_pkt_rx
  import axis_pkt_rx_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 64,
  parameter int MAX_PKTS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
`ifdef AXIS_RX_STALL_EN
  input  logic [3:0]              stall_cfg,
`endif
  output logic                    pkt_avail,
  output logic [$clog2(DEPTH):0]  pkt_len,
  output logic [TDATA_WIDTH-1:0]  rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] P_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] P_ONE   = {{AW{1'b0}}, 1'b1};

  logic [TDATA_WIDTH-1:0] r_ram [DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [AW:0]            r_commit_ptr;
  logic [AW:0]            r_cur_len;
  logic [AW:0]            r_rem;
  logic [DROP_CNT_W-1:0]  r_drop_cnt;
  wr_state_e              r_wr_state;
  wr_state_e              w_wr_state_next;
  rd_state_e              r_rd_state;
  rd_state_e              w_rd_state_next;

  logic [AW:0] w_used;
  logic        w_room;
  logic        w_accept;
  logic        w_ram_we;
  logic        w_push;
  logic        w_rewind;
  logic        w_drop_inc;
  logic        w_pop;
  logic        w_rd_adv;
  logic        w_rem_load;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [AW:0] w_fifo_head;

  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_room   = (w_used < P_DEPTH);
  assign w_accept = s_axis_tvalid && s_axis_tready;

`ifdef AXIS_RX_STALL_EN
  logic [3:0] r_stall_cnt;

  assign s_axis_tready = !rst && !w_fifo_full && (r_stall_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_stall_cnt <= 4'd0;
    else if (w_accept)           r_stall_cnt <= stall_cfg;
    else if (r_stall_cnt != 4'd0) r_stall_cnt <= r_stall_cnt - 4'd1;
  end
`else
  assign s_axis_tready = !rst && !w_fifo_full;
`endif

  always_comb begin
    w_wr_state_next = r_wr_state;
    w_ram_we        = 1'b0;
    w_push          = 1'b0;
    w_rewind        = 1'b0;
    w_drop_inc      = 1'b0;
    if (w_accept) begin
      case (r_wr_state)
        RECV: begin
          if (w_room) begin
            w_ram_we = 1'b1;
            w_push   = s_axis_tlast;
          end else begin
            // RAM is full of this packet plus unread ones: abandon it whole.
            w_rewind = 1'b1;
            if (s_axis_tlast) w_drop_inc = 1'b1;
            else              w_wr_state_next = DROP;
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            w_drop_inc      = 1'b1;
            w_wr_state_next = RECV;
          end
        end
        default: w_wr_state_next = RECV;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state   <= RECV;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_cur_len    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_ram_we) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
        if (w_push) begin
          r_commit_ptr <= r_wr_ptr + P_ONE;
          r_cur_len    <= '0;
        end else begin
          r_cur_len <= r_cur_len + P_ONE;
        end
      end else if (w_rewind) begin
        r_wr_ptr  <= r_commit_ptr;
        r_cur_len <= '0;
      end
      if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  axis_pkt_rx_len_fifo #(
    .WIDTH (AW + 1),
    .DEPTH (MAX_PKTS)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (r_cur_len + P_ONE),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  always_comb begin
    w_rd_state_next = r_rd_state;
    rd_valid        = 1'b0;
    rd_last         = 1'b0;
    w_pop           = 1'b0;
    w_rd_adv        = 1'b0;
    w_rem_load      = 1'b0;
    case (r_rd_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_rem_load      = 1'b1;
          w_rd_state_next = READ;
        end
      end
      READ: begin
        rd_valid = 1'b1;
        rd_last  = (r_rem == P_ONE);
        if (rd_ready) begin
          w_rd_adv = 1'b1;
          if (r_rem == P_ONE) begin
            w_pop           = 1'b1;
            w_rd_state_next = IDLE;
          end
        end
      end
      default: w_rd_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= IDLE;
      r_rd_ptr   <= '0;
      r_rem      <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (w_rem_load) r_rem <= w_fifo_head;
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
        r_rem    <= r_rem - P_ONE;
      end
    end
  end

  assign rd_data   = (r_rd_state == READ) ? r_ram[r_rd_ptr[AW-1:0]] : '0;
  assign pkt_avail = !w_fifo_empty;
  assign pkt_len   = w_fifo_empty ? '0 : w_fifo_head;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Self-checking bench for axis_pkt_rx: queue-based packet model plus directed scenarios.
module tb_axis_pkt_rx;

  localparam int W        = 32;
  localparam int DEPTH    = 64;
  localparam int MAX_PKTS = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          pkt_avail;
  logic [LW-1:0] pkt_len;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [15:0]   drop_cnt;
`ifdef AXIS_RX_STALL_EN
  logic [3:0]    stall_cfg = 4'd0;
`endif

  axis_pkt_rx #(.TDATA_WIDTH(W), .DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
`ifdef AXIS_RX_STALL_EN
    .stall_cfg     (stall_cfg),
`endif
    .pkt_avail     (pkt_avail),
    .pkt_len       (pkt_len),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: committed-unread beats, committed lengths, the partial packet in flight.
  logic [W-1:0] m_data[$];
  int           m_len[$];
  logic [W-1:0] m_cur[$];
  bit           m_dropping = 0;
  int           m_drops = 0;
  bit           m_present = 0;
  int           m_rd_idx = 0;
  int           m_stall = 0;

  function automatic bit m_tready();
    return !rst && (m_len.size() < MAX_PKTS) && (m_stall == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    int  used;
    int  nlen;
    bit  acc;
    if (rst) begin
      m_data.delete(); m_len.delete(); m_cur.delete();
      m_dropping = 0; m_drops = 0; m_present = 0; m_rd_idx = 0; m_stall = 0;
    end else begin
      used = m_data.size() + m_cur.size();
      nlen = m_len.size();
      acc  = s_axis_tvalid && m_tready();
`ifdef AXIS_RX_STALL_EN
      if (acc) m_stall = int'(stall_cfg);
      else if (m_stall > 0) m_stall--;
`endif
      // A head packet is presented the cycle after it becomes visible.
      if (!m_present) begin
        if (nlen > 0) m_present = 1;
      end else if (rd_ready) begin
        void'(m_data.pop_front());
        m_rd_idx++;
        if (m_rd_idx == m_len[0]) begin
          void'(m_len.pop_front());
          m_rd_idx  = 0;
          m_present = 0;
        end
      end
      if (acc) begin
        if (m_dropping) begin
          if (s_axis_tlast) begin m_drops++; m_dropping = 0; end
        end else if (used < DEPTH) begin
          m_cur.push_back(s_axis_tdata);
          if (s_axis_tlast) begin
            m_len.push_back(m_cur.size());
            foreach (m_cur[i]) m_data.push_back(m_cur[i]);
            m_cur.delete();
          end
        end else begin
          m_cur.delete();
          if (s_axis_tlast) m_drops++;
          else m_dropping = 1;
        end
      end
    end
  end

  logic [W-1:0] got[$];
  bit           got_last[$];
  int           got_cyc[$];
  int           n_last = 0;

  always @(negedge clk) begin
    logic [LW-1:0] e_len;
    logic [W-1:0]  e_data;
    bit            e_last;
    e_len  = (m_len.size() > 0) ? LW'(m_len[0]) : '0;
    e_data = m_present ? m_data[0] : '0;
    e_last = m_present && (m_len[0] - m_rd_idx == 1);
    chk("tready",    {63'd0, s_axis_tready}, {63'd0, m_tready()});
    chk("pkt_avail", {63'd0, pkt_avail},     {63'd0, m_len.size() > 0});
    chk("pkt_len",   64'(pkt_len),           64'(e_len));
    chk("rd_valid",  {63'd0, rd_valid},      {63'd0, m_present});
    chk("rd_data",   64'(rd_data),           64'(e_data));
    chk("rd_last",   {63'd0, rd_last},       {63'd0, e_last});
    chk("drop_cnt",  64'(drop_cnt),          64'((m_drops > 65535) ? 65535 : m_drops));
    if (rd_valid && rd_ready) begin
      got.push_back(rd_data);
      got_last.push_back(rd_last);
      got_cyc.push_back(cyc);
      if (rd_last) n_last++;
      $display("rd beat data=%08h last=%0b cycle=%0d", rd_data, rd_last, cyc);
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 300) begin t++; @(negedge clk); end
    if (t >= 300) begin
      checks++; failures++;
      $display("FAIL send_timeout: tready=%0b required 1 within 300 cycles", s_axis_tready);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) send_beat(base + W'(i), i == n - 1);
    $display("sent pkt len=%0d base=%08h cycle=%0d", n, base, cyc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rd_ready = 1'b1;
    @(negedge clk);
    while ((pkt_avail || rd_valid) && t < 2000) begin t++; @(negedge clk); end
    if (t >= 2000) begin
      checks++; failures++;
      $display("FAIL drain_timeout: pkt_avail=%0b required 0 within 2000 cycles", pkt_avail);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("rst_avail",  {63'd0, pkt_avail},     64'd0);
    chk("rst_drop",   64'(drop_cnt),          64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single 4-beat packet
    rd_ready = 1'b1;
    got.delete(); got_last.delete();
    send_pkt(4, 32'hA0);
    @(negedge clk);
    chk("t1_avail", {63'd0, pkt_avail}, 64'd1);
    chk("t1_len",   64'(pkt_len),       64'd4);
    drain();
    chk("t1_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t1_data", 64'(got[i]), 64'(32'hA0 + i));
    chk("t1_last0", {63'd0, got_last[0]}, 64'd0);
    chk("t1_last3", {63'd0, got_last[3]}, 64'd1);
    chk("t1_drop",  64'(drop_cnt), 64'd0);

    // 2: oversize packet dropped, following packet survives
    rd_ready = 1'b0;
    send_pkt(70, 32'h1000);
    send_pkt(2, 32'h2000);
    @(negedge clk);
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_len",  64'(pkt_len),  64'd2);
    @(posedge clk); #1;
    got.delete();
    drain();
    chk("t2_count", 64'(got.size()), 64'd2);
    chk("t2_d0", 64'(got[0]), 64'h2000);
    chk("t2_d1", 64'(got[1]), 64'h2001);

    // 3: length FIFO full blocks input; one read frees it
    rd_ready = 1'b0;
    for (int i = 0; i < MAX_PKTS; i++) send_pkt(1, 32'h3000 + W'(i));
    @(negedge clk);
    chk("t3_tready_full", {63'd0, s_axis_tready}, 64'd0);
    chk("t3_rd_valid",    {63'd0, rd_valid},      64'd1);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(negedge clk);
    chk("t3_tready_back", {63'd0, s_axis_tready}, 64'd1);
    @(posedge clk); #1;
    drain();

    // 4: back-to-back 8-beat packets
    rd_ready = 1'b1;
    got.delete(); got_cyc.delete();
    for (int p = 0; p < 6; p++) send_pkt(8, 32'h4000 + W'(p * 16));
    drain();
    chk("t4_drop",  64'(drop_cnt), 64'd1);
    chk("t4_count", 64'(got.size()), 64'd48);
    for (int i = 0; i < 48; i++) chk("t4_data", 64'(got[i]), 64'(32'h4000 + (i / 8) * 16 + i % 8));
    for (int p = 1; p < 6; p++) chk("t4_gap", 64'(got_cyc[8 * p] - got_cyc[8 * p - 1]), 64'd2);

    // 5: reset mid-packet
    for (int i = 0; i < 3; i++) send_beat(32'h5100 + W'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("t5_avail",  {63'd0, pkt_avail},     64'd0);
    chk("t5_len",    64'(pkt_len),           64'd0);
    chk("t5_valid",  {63'd0, rd_valid},      64'd0);
    chk("t5_last",   {63'd0, rd_last},       64'd0);
    chk("t5_data",   64'(rd_data),           64'd0);
    chk("t5_drop",   64'(drop_cnt),          64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    n_last = 0;
    got.delete();
    send_pkt(2, 32'h5000);
    drain();
    chk("t5_pkts", 64'(n_last), 64'd1);
    chk("t5_d0",   64'(got[0]), 64'h5000);
    chk("t5_d1",   64'(got[1]), 64'h5001);

`ifdef AXIS_RX_STALL_EN
    // 6: injected backpressure after every accepted beat
    begin
      int n;
      stall_cfg = 4'd3;
      rd_ready  = 1'b1;
      got.delete();
      for (int b = 0; b < 3; b++) begin
        s_axis_tdata = 32'h6000 + W'(b); s_axis_tlast = (b == 2); s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 20) begin n++; @(negedge clk); end
        if (b > 0) chk("t6_stall", 64'(n), 64'd3);
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 20) begin n++; @(negedge clk); end
      chk("t6_stall_end", 64'(n), 64'd3);
      @(posedge clk); #1;
      drain();
      chk("t6_count", 64'(got.size()), 64'd3);
      for (int i = 0; i < 3; i++) chk("t6_data", 64'(got[i]), 64'(32'h6000 + i));
      stall_cfg = 4'd0;
    end
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
